// File: rtl/onehot_demux.sv
// onehot_demux: single-register stream demultiplexer.
// One valid/ready input stream carries a one-hot destination tag.
// Each legal beat is registered once and presented on exactly one of N output ports.
// Beats with an illegal select (zero bits or several bits set) are consumed and
// discarded, and they are counted in a saturating drop counter.
module onehot_demux #(
  parameter int unsigned DW = 8,
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 8
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic [N-1:0]    i_sel,
  input  logic [DW-1:0]   i_data,
  output logic [N-1:0]    o_valid,
  input  logic [N-1:0]    o_ready,
  output logic [N*DW-1:0] o_data,
  output logic [CW-1:0]   drop_count
);

  logic          full;
  logic [N-1:0]  sel_q;
  logic [DW-1:0] data_q;
  logic [CW-1:0] drop_q;

  logic out_fire;
  logic in_fire;
  logic sel_legal;

  // Exactly one bit set: non-zero, and clearing the lowest set bit leaves nothing.
  assign sel_legal = (i_sel != '0) && ((i_sel & (i_sel - N'(1))) == '0);

  // Only the port that is actually valid can complete a transfer, so ready bits on idle ports are ignored.
  assign out_fire = |(o_valid & o_ready);
  assign in_fire  = i_valid & i_ready;

  // Combinational from o_ready: a draining register can accept a new beat in the same cycle.
  assign i_ready  = !full | out_fire;

  assign o_valid    = full ? sel_q : '0;
  assign drop_count = drop_q;

  // Steer the held payload onto its port slice and hold every other slice at zero.
  always_comb begin
    o_data = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (full && sel_q[j]) begin
        o_data[j*DW +: DW] = data_q;
      end
    end
  end

  // Holding register: a legal accept loads it; otherwise a drain empties it.
  // An illegal accept while full implies out_fire, so it falls into the drain branch.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      full   <= 1'b0;
      sel_q  <= '0;
      data_q <= '0;
    end else if (in_fire && sel_legal) begin
      full   <= 1'b1;
      sel_q  <= i_sel;
      data_q <= i_data;
    end else if (out_fire) begin
      full   <= 1'b0;
    end
  end

  // Saturating count of beats discarded for an illegal select.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      drop_q <= '0;
    end else if (in_fire && !sel_legal && (drop_q != '1)) begin
      drop_q <= drop_q + CW'(1);
    end
  end

endmodule

// File: tb/tb_onehot_demux.sv
// Directed bench for onehot_demux.
// Accepted legal beats are queued as expected outputs and checked when a port drains.
module tb_onehot_demux;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        i_valid;
  logic        i_ready;
  logic [3:0]  i_sel;
  logic [7:0]  i_data;
  logic [3:0]  o_valid;
  logic [3:0]  o_ready;
  logic [31:0] o_data;
  logic [7:0]  drop_count;

  // Second instance with a 2-bit counter for the saturation case.
  logic        s_valid;
  logic        s_ready;
  logic [3:0]  s_sel;
  logic [7:0]  s_data;
  logic [3:0]  s_ovalid;
  logic [3:0]  s_oready;
  logic [31:0] s_odata;
  logic [1:0]  s_drop;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] data;
  } beat_t;

  beat_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  onehot_demux #(.DW(8), .N(4), .CW(8)) dut (
    .clk(clk), .aresetn(aresetn),
    .i_valid(i_valid), .i_ready(i_ready), .i_sel(i_sel), .i_data(i_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .drop_count(drop_count)
  );

  onehot_demux #(.DW(8), .N(4), .CW(2)) dut_sat (
    .clk(clk), .aresetn(aresetn),
    .i_valid(s_valid), .i_ready(s_ready), .i_sel(s_sel), .i_data(s_data),
    .o_valid(s_ovalid), .o_ready(s_oready), .o_data(s_odata),
    .drop_count(s_drop)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Score the drain/accept that the next edge will perform, then advance one cycle.
  task automatic tick();
    beat_t b;
    int    idx;
    if (|(o_valid & o_ready)) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        b = sb.pop_front();
        idx = 0;
        for (int j = 0; j < 4; j++) if (b.sel[j]) idx = j;
        check("sb_port", 64'(o_valid), 64'(b.sel));
        check("sb_data", 64'(o_data[idx*8 +: 8]), 64'(b.data));
      end
    end
    if (i_valid && i_ready && ($countones(i_sel) == 1)) begin
      b.sel  = i_sel;
      b.data = i_data;
      sb.push_back(b);
    end
    @(posedge clk);
    #1;
  endtask

  logic [1:0] sat_exp [5];
  logic [3:0] sat_sel [5];

  initial begin
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    sat_sel = '{4'b0000, 4'b0110, 4'b1111, 4'b0011, 4'b0000};

    aresetn = 1'b0;
    i_valid = 1'b0; i_sel = '0; i_data = '0; o_ready = '0;
    s_valid = 1'b0; s_sel = '0; s_data = '0; s_oready = '0;

    // Reset state
    #12;
    check("rst_ovalid", 64'(o_valid), 64'h0);
    check("rst_odata", 64'(o_data), 64'h0);
    check("rst_drop", 64'(drop_count), 64'h0);
    check("rst_iready", 64'(i_ready), 64'h1);
    @(negedge clk);
    aresetn = 1'b1;

    // Single beat with backpressure, then drain
    i_valid = 1'b1; i_sel = 4'b0100; i_data = 8'hA5; o_ready = 4'b0000;
    tick();
    i_valid = 1'b0; i_sel = '0; i_data = '0;
    #1;
    check("single_ovalid", 64'(o_valid), 64'h4);
    check("single_odata", 64'(o_data), 64'h00A5_0000);
    check("single_iready", 64'(i_ready), 64'h0);
    tick();
    check("single_hold", 64'(o_valid), 64'h4);
    o_ready = 4'b0100;
    #1;
    check("single_drain_iready", 64'(i_ready), 64'h1);
    tick();
    check("single_empty", 64'(o_valid), 64'h0);
    o_ready = 4'b0000;

    // Streaming to all ports, no bubbles
    o_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1;
      i_sel   = 4'(1 << k);
      i_data  = 8'((k + 1) * 16);
      #1;
      check("stream_iready", 64'(i_ready), 64'h1);
      if (k > 0) check("stream_port", 64'(o_valid), 64'(1 << (k - 1)));
      tick();
    end
    i_valid = 1'b0; i_sel = '0; i_data = '0;
    #1;
    check("stream_last_port", 64'(o_valid), 64'h8);
    check("stream_last_data", 64'(o_data), 64'h4000_0000);
    tick();
    check("stream_empty", 64'(o_valid), 64'h0);

    // Ready on the wrong ports does not drain the beat
    o_ready = 4'b0000;
    i_valid = 1'b1; i_sel = 4'b0010; i_data = 8'h5C;
    tick();
    i_valid = 1'b0; i_sel = '0; i_data = '0;
    o_ready = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("wrong_ovalid", 64'(o_valid), 64'h2);
      check("wrong_odata", 64'(o_data), 64'h0000_5C00);
      check("wrong_iready", 64'(i_ready), 64'h0);
      tick();
    end
    o_ready = 4'b1111;
    #1;
    check("wrong_drain_iready", 64'(i_ready), 64'h1);
    tick();
    check("wrong_empty", 64'(o_valid), 64'h0);

    // Illegal selects are consumed and counted
    o_ready = 4'b0000;
    i_valid = 1'b1; i_sel = 4'b0000; i_data = 8'h77;
    #1;
    check("ill0_iready", 64'(i_ready), 64'h1);
    tick();
    check("ill0_drop", 64'(drop_count), 64'h1);
    check("ill0_ovalid", 64'(o_valid), 64'h0);
    i_sel = 4'b0110;
    #1;
    check("ill2_iready", 64'(i_ready), 64'h1);
    tick();
    check("ill2_drop", 64'(drop_count), 64'h2);
    check("ill2_ovalid", 64'(o_valid), 64'h0);
    i_valid = 1'b0; i_sel = '0; i_data = '0;

    // Reset mid-transfer clears immediately
    i_valid = 1'b1; i_sel = 4'b1000; i_data = 8'hEE;
    tick();
    i_valid = 1'b0; i_sel = '0; i_data = '0;
    #1;
    check("pre_rst_ovalid", 64'(o_valid), 64'h8);
    #2;
    aresetn = 1'b0;
    #1;
    check("arst_ovalid", 64'(o_valid), 64'h0);
    check("arst_odata", 64'(o_data), 64'h0);
    check("arst_drop", 64'(drop_count), 64'h0);
    check("arst_iready", 64'(i_ready), 64'h1);
    sb.delete();
    @(negedge clk);
    aresetn = 1'b1;

    // Saturation with a 2-bit counter
    check("sat_init", 64'(s_drop), 64'h0);
    s_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      s_sel  = sat_sel[k];
      s_data = 8'(k);
      #1;
      check("sat_iready", 64'(s_ready), 64'h1);
      @(posedge clk);
      #1;
      check("sat_count", 64'(s_drop), 64'(sat_exp[k]));
      check("sat_ovalid", 64'(s_ovalid), 64'h0);
    end
    s_valid = 1'b0;

    check("sb_drained", 64'(sb.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
